dev_inbuf_fifo: RTL



---
 rtl/dev_inbuf_fifo_pkg.sv | 16 +
 rtl/dev_inbuf_fifo_if.sv | 38 +++
 rtl/dev_inbuf_fifo_ptr_ctrl.sv | 101 ++++++++++
 rtl/dev_inbuf_fifo.sv | 60 ++++++
 4 files changed

// File: rtl/dev_inbuf_fifo_pkg.sv
// Shared types and width helpers for the input buffer FIFO.
// Pointer and level widths derive from DEPTH so every file sizes them the same way.
package dev_inbuf_fifo_pkg;

  typedef logic [7:0] byte_t;

  // Pointer carries one extra bit beyond the index to tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dev_inbuf_fifo_if.sv
// Bus between the input buffer FIFO and its producer/consumer.
// The master drives strobes and write data; the slave (the FIFO) drives data_out and status.
interface dev_inbuf_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  import dev_inbuf_fifo_pkg::*;

  localparam int LVL_W = lvl_w(DEPTH);

  // push_back/pop_front are single-cycle strobes sampled on the rising edge.
  // A push is taken unless the FIFO is full with no pop taken the same edge;
  // a pop is taken only when not empty. Status outputs are registered and
  // reflect the result of the previous edge; data_out is the head word (FWFT).
  logic             push_back;
  logic [WIDTH-1:0] data_in;
  logic             pop_front;
  logic             flush;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic [LVL_W-1:0] level;
  logic             almost_full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push_back, data_in, pop_front, flush, clr_err,
    input  data_out, empty, full, level, almost_full, overflow, underflow
  );

  modport slave (
    input  push_back, data_in, pop_front, flush, clr_err,
    output data_out, empty, full, level, almost_full, overflow, underflow
  );

endinterface

// File: rtl/dev_inbuf_fifo_ptr_ctrl.sv
// Pointer, level and status-flag control for the input buffer FIFO.
// Independent of word width; the top owns the storage array.
module dev_inbuf_fifo_ptr_ctrl
  import dev_inbuf_fifo_pkg::*;
#(
  parameter  int DEPTH        = 16,
  parameter  int AFULL_THRESH = DEPTH - 2,
  localparam int PTR_W        = ptr_w(DEPTH),
  localparam int IDX_W        = PTR_W - 1,
  localparam int LVL_W        = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic             clr_err_i,
  output logic             we_o,
  output logic [IDX_W-1:0] wr_idx_o,
  output logic [IDX_W-1:0] rd_idx_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [LVL_W-1:0] level_o,
  output logic             afull_o,
  output logic             ovf_o,
  output logic             udf_o
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dev_inbuf_fifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_thresh
    $error("dev_inbuf_fifo: AFULL_THRESH must be in 1..DEPTH");
  end

  localparam logic [PTR_W-1:0] FULL_XOR  = {1'b1, {IDX_W{1'b0}}};
  localparam logic [LVL_W-1:0] THRESH_LV = LVL_W'(AFULL_THRESH);

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             empty_q, empty_d, full_q, full_d, afull_q, afull_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic             push_ok, pop_ok, ovf_set, udf_set;

  always_comb begin
    pop_ok  = pop_i && !empty_q && !flush_i;
    // A full FIFO still takes a push when the head leaves on the same edge.
    push_ok = push_i && (!full_q || pop_ok) && !flush_i;
    ovf_set = push_i && !push_ok && !flush_i;
    udf_set = pop_i && empty_q && !flush_i;

    wr_d    = wr_q + PTR_W'(push_ok);
    rd_d    = rd_q + PTR_W'(pop_ok);
    level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      level_d = '0;
    end

    empty_d = (wr_d == rd_d);
    full_d  = ((wr_d ^ rd_d) == FULL_XOR);
    afull_d = (level_d >= THRESH_LV);
    // A new error on the same edge as clr_err keeps the flag set.
    ovf_d   = ovf_set || (ovf_q && !clr_err_i);
    udf_d   = udf_set || (udf_q && !clr_err_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign we_o     = push_ok;
  assign wr_idx_o = wr_q[IDX_W-1:0];
  assign rd_idx_o = rd_q[IDX_W-1:0];
  assign empty_o  = empty_q;
  assign full_o   = full_q;
  assign level_o  = level_q;
  assign afull_o  = afull_q;
  assign ovf_o    = ovf_q;
  assign udf_o    = udf_q;

endmodule

// File: rtl/dev_inbuf_fifo.sv
// First-word-fall-through input buffer: storage array plus pointer/flag control.
// data_out is the combinational read of the head entry, forced to 0 while empty.
module dev_inbuf_fifo
  import dev_inbuf_fifo_pkg::*;
#(
  parameter  int WIDTH        = $bits(byte_t),
  parameter  int DEPTH        = 16,
  parameter  int AFULL_THRESH = DEPTH - 2,
  localparam int IDX_W        = ptr_w(DEPTH) - 1,
  localparam int LVL_W        = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  dev_inbuf_fifo_if.slave   bus
);

  logic             we;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             empty, full, afull, ovf, udf;
  logic [LVL_W-1:0] level;

  dev_inbuf_fifo_ptr_ctrl #(
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_ptr_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (bus.push_back),
    .pop_i     (bus.pop_front),
    .flush_i   (bus.flush),
    .clr_err_i (bus.clr_err),
    .we_o      (we),
    .wr_idx_o  (wr_idx),
    .rd_idx_o  (rd_idx),
    .empty_o   (empty),
    .full_o    (full),
    .level_o   (level),
    .afull_o   (afull),
    .ovf_o     (ovf),
    .udf_o     (udf)
  );

  // Storage is deliberately not reset so it maps onto plain RAM.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_idx] <= bus.data_in;
    end
  end

  assign bus.data_out    = empty ? '0 : mem_q[rd_idx];
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.level       = level;
  assign bus.almost_full = afull;
  assign bus.overflow    = ovf;
  assign bus.underflow   = udf;

endmodule
